// File: rtl/sopc_mem_arbiter.sv
// sopc_mem_arbiter: N-master memory front end with round-robin arbitration and LATENCY wait states.
// Define ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-first priority.
module sopc_mem_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MASK_WIDTH  = DATA_WIDTH / 8,
    parameter int LATENCY     = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS-1:0]            m_req,
    input  logic [NUM_MASTERS-1:0]            m_we,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
    input  logic [NUM_MASTERS*MASK_WIDTH-1:0] m_mask,
    output logic [DATA_WIDTH-1:0]             m_rdata,
    output logic [NUM_MASTERS-1:0]            m_ready,
    output logic [NUM_MASTERS-1:0]            grant,
    output logic                              mem_req,
    output logic                              mem_we,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [DATA_WIDTH-1:0]             mem_wdata,
    output logic [MASK_WIDTH-1:0]             mem_mask,
    input  logic [DATA_WIDTH-1:0]             mem_rdata
);
    localparam int PW = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1;
    localparam logic [7:0] LAT_M1 = LATENCY > 0 ? 8'(LATENCY - 1) : 8'd0;
    localparam logic [NUM_MASTERS-1:0] ONE = NUM_MASTERS'(1);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    state_t                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [PW-1:0]         gidx_q, gidx_d, win, idx, ptr;
    logic                  any_req;
    logic                  we_q, sel_we, src_we;
    logic [ADDR_WIDTH-1:0] addr_q, sel_addr, src_addr, mem_addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, sel_wdata, src_wdata, mem_wdata_q, rdata_q;
    logic [MASK_WIDTH-1:0] mask_q, sel_mask, src_mask, mem_mask_q;

`ifdef ARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    logic [PW-1:0] ptr_q, ptr_d;
    assign ptr_d = state_q == RESP ? PW'((int'(gidx_q) + 1) % NUM_MASTERS) : ptr_q;
    always_ff @(posedge clk)
        ptr_q <= rst ? '0 : ptr_d;
    assign ptr = ptr_q;
`endif

    // Scan from the far end so the last hit is the first requester at or after ptr.
    always_comb begin
        win = '0;
        idx = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr) + k) % NUM_MASTERS);
            if (m_req[idx]) win = idx;
        end
    end

    assign any_req   = |m_req;
    assign sel_we    = m_we[win];
    assign sel_addr  = m_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_wdata = m_wdata[win*DATA_WIDTH +: DATA_WIDTH];
    assign sel_mask  = m_mask[win*MASK_WIDTH +: MASK_WIDTH];
    assign src_we    = state_q == IDLE ? sel_we : we_q;
    assign src_addr  = state_q == IDLE ? sel_addr : addr_q;
    assign src_wdata = state_q == IDLE ? sel_wdata : wdata_q;
    assign src_mask  = state_q == IDLE ? sel_mask : mask_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gidx_d  = gidx_q;
        case (state_q)
            IDLE: if (any_req) begin
                state_d = LATENCY > 0 ? WAIT : ACCESS;
                cnt_d   = LAT_M1;
                gidx_d  = win;
            end
            WAIT: begin
                state_d = cnt_q == 8'd0 ? ACCESS : WAIT;
                cnt_d   = cnt_q == 8'd0 ? 8'd0 : cnt_q - 8'd1;
            end
            ACCESS:  state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    // The backend bus registers load only on entry to ACCESS so they hold between accesses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            gidx_q      <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mask_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_mask_q  <= '0;
            rdata_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gidx_q  <= gidx_d;
            if (state_q == IDLE && any_req) begin
                we_q    <= sel_we;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                mask_q  <= sel_mask;
            end
            if (state_d == ACCESS) begin
                mem_addr_q  <= src_addr;
                mem_wdata_q <= src_wdata;
                mem_mask_q  <= src_we ? src_mask : '0;
            end
            if (state_q == ACCESS && !we_q) rdata_q <= mem_rdata;
        end
    end

    assign grant     = state_q == IDLE ? (any_req ? ONE << win : '0) : ONE << gidx_q;
    assign m_ready   = state_q == RESP ? ONE << gidx_q : '0;
    assign mem_req   = state_q == ACCESS;
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_mask  = mem_mask_q;
    assign m_rdata   = rdata_q;
endmodule

// File: tb/tb_sopc_mem_arbiter.sv
// tb_sopc_mem_arbiter: directed and random checks of two arbiter instances (LATENCY 2 and 0)
// against a transaction-timeline reference model.
module tb_sopc_mem_arbiter;
    localparam int N = 2, AW = 32, DW = 32, MW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    req[2], we[2], ready[2], grant[2];
    logic [N*AW-1:0] addr[2];
    logic [N*DW-1:0] wdata[2];
    logic [N*MW-1:0] mask[2];
    logic [DW-1:0]   mrdata[2], rdata[2], mwdata[2];
    logic [AW-1:0]   maddr[2];
    logic [MW-1:0]   mmask[2];
    logic            mreq[2], mwe[2];

    sopc_mem_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(2)) u0 (
        .clk(clk), .rst(rst), .m_req(req[0]), .m_we(we[0]), .m_addr(addr[0]), .m_wdata(wdata[0]),
        .m_mask(mask[0]), .m_rdata(rdata[0]), .m_ready(ready[0]), .grant(grant[0]),
        .mem_req(mreq[0]), .mem_we(mwe[0]), .mem_addr(maddr[0]), .mem_wdata(mwdata[0]),
        .mem_mask(mmask[0]), .mem_rdata(mrdata[0]));

    sopc_mem_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(0)) u1 (
        .clk(clk), .rst(rst), .m_req(req[1]), .m_we(we[1]), .m_addr(addr[1]), .m_wdata(wdata[1]),
        .m_mask(mask[1]), .m_rdata(rdata[1]), .m_ready(ready[1]), .grant(grant[1]),
        .mem_req(mreq[1]), .mem_we(mwe[1]), .mem_addr(maddr[1]), .mem_wdata(mwdata[1]),
        .mem_mask(mmask[1]), .mem_rdata(mrdata[1]));

    int errors = 0, checks = 0, cyc = 0;
    bit rand_mode = 0, oneshot = 1, stop = 0, rand_rdata = 0;

    // Reference model: one transaction per instance, timed relative to its grant cycle t0.
    bit            busy[2];
    int            t0[2], win[2], ptr[2];
    logic          lwe[2];
    logic [AW-1:0] laddr[2], e_maddr[2];
    logic [DW-1:0] lwdata[2], e_mwdata[2], e_rdata[2];
    logic [MW-1:0] lmask[2], e_mmask[2];
    logic [N-1:0]  rdy_seen[2];

    function automatic int lat(int d);
        return d == 0 ? 2 : 0;
    endfunction

    function automatic int pick(logic [N-1:0] r, int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return 0;
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset(int d);
        busy[d] = 0; ptr[d] = 0; e_rdata[d] = '0; e_maddr[d] = '0;
        e_mwdata[d] = '0; e_mmask[d] = '0; rdy_seen[d] = '0;
    endtask

    task automatic model_check(int d);
        int l, rel;
        logic [N-1:0] eg, er;
        logic emr;
        l = lat(d);
        if (!busy[d] && |req[d]) begin
            win[d] = pick(req[d], ptr[d]);
            busy[d] = 1; t0[d] = cyc;
            lwe[d] = we[d][win[d]];
            laddr[d] = addr[d][win[d]*AW +: AW];
            lwdata[d] = wdata[d][win[d]*DW +: DW];
            lmask[d] = mask[d][win[d]*MW +: MW];
        end
        rel = cyc - t0[d];
        eg = '0; er = '0;
        if (busy[d]) eg[win[d]] = 1'b1;
        if (busy[d] && rel == l + 2) er[win[d]] = 1'b1;
        emr = busy[d] && rel == l + 1;
        if (emr) begin
            e_maddr[d] = laddr[d]; e_mwdata[d] = lwdata[d];
            e_mmask[d] = lwe[d] ? lmask[d] : '0;
        end
        chk($sformatf("d%0d_grant", d), grant[d], eg);
        chk($sformatf("d%0d_ready", d), ready[d], er);
        chk($sformatf("d%0d_mem_req", d), mreq[d], emr);
        chk($sformatf("d%0d_mem_we", d), mwe[d], emr && lwe[d]);
        chk($sformatf("d%0d_mem_addr", d), maddr[d], e_maddr[d]);
        chk($sformatf("d%0d_mem_wdata", d), mwdata[d], e_mwdata[d]);
        chk($sformatf("d%0d_mem_mask", d), mmask[d], e_mmask[d]);
        chk($sformatf("d%0d_m_rdata", d), rdata[d], e_rdata[d]);
        if (emr && !lwe[d]) e_rdata[d] = mrdata[d];
        if (busy[d] && rel == l + 2) begin
            busy[d] = 0;
`ifdef ARB_FIXED_PRIO_EN
            ptr[d] = 0;
`else
            ptr[d] = (win[d] + 1) % N;
`endif
        end
        rdy_seen[d] = er;
    endtask

    task automatic step();
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            if (rst) model_reset(d);
            else model_check(d);
        @(posedge clk);
        cyc++;
        #1;
        if (rand_mode) rst = !stop && ($urandom_range(99) == 0);
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < N; i++)
                if (rdy_seen[d][i] && (oneshot || stop || (rand_mode && $urandom_range(1) == 1)))
                    req[d][i] = 1'b0;
                else if (rand_mode && !stop && !req[d][i] && $urandom_range(3) == 0)
                    req[d][i] = 1'b1;
            if (rand_mode) begin
                we[d] = N'($urandom);
                addr[d] = {$urandom, $urandom};
                wdata[d] = {$urandom, $urandom};
                mask[d] = (N*MW)'($urandom);
            end
            if (rand_rdata) mrdata[d] = $urandom;
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            req[d] = '0; we[d] = '0; addr[d] = '0; wdata[d] = '0; mask[d] = '0; mrdata[d] = '0;
        end
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_grant%0d", d), grant[d], 0);
            chk($sformatf("rst_ready%0d", d), ready[d], 0);
            chk($sformatf("rst_rdata%0d", d), rdata[d], 0);
            chk($sformatf("rst_mem_req%0d", d), mreq[d], 0);
            chk($sformatf("rst_mem_addr%0d", d), maddr[d], 0);
        end

        // Single reads: master1 on the LATENCY=2 instance, master0 on the LATENCY=0 instance.
        req[0] = 2'b10; we[0] = 2'b00; addr[0][AW +: AW] = 32'h8000_0010; mrdata[0] = 32'hDEAD_BEEF;
        req[1] = 2'b01; we[1] = 2'b00; addr[1][0 +: AW] = 32'h0000_0040; mrdata[1] = 32'hCAFE_F00D;
        repeat (8) step();
        chk("t1_rdata", rdata[0], 32'hDEAD_BEEF);
        chk("t0lat_rdata", rdata[1], 32'hCAFE_F00D);

        // Master0 write; the read-data register must not move.
        we[0] = 2'b01; addr[0][0 +: AW] = 32'h100; wdata[0][0 +: DW] = 32'h1234_5678;
        mask[0][0 +: MW] = 4'b0011; req[0] = 2'b01;
        repeat (7) step();
        chk("wr_rdata_hold", rdata[0], 32'hDEAD_BEEF);
        chk("wr_mem_mask_hold", mmask[0], 4'b0011);

        // Both masters reading continuously, then drained.
        we[0] = '0; we[1] = '0; req[0] = 2'b11; req[1] = 2'b11;
        oneshot = 0; rand_rdata = 1;
        repeat (30) step();
        oneshot = 1;
        repeat (14) step();

        // Serve master0 so the pointer moves to 1, then reset in the middle of WAIT.
        req[0] = 2'b01;
        repeat (6) step();
        req[0] = 2'b01;
        step();
        step();
        rst = 1'b1; req[0] = 2'b00;
        step();
        rst = 1'b0;
        step();
        chk("abort_grant", grant[0], 0);
        chk("abort_ready", ready[0], 0);
        chk("abort_mem_req", mreq[0], 0);
        req[0] = 2'b11;
        #1;
        chk("abort_ptr_restart", grant[0], 2'b01);
        repeat (12) step();

        // Random traffic with occasional resets, then drain.
        rand_mode = 1;
        repeat (400) step();
        stop = 1;
        repeat (30) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
